// File: rtl/mem_arbiter.sv
// Byte-serial memory arbiter: shares one 8-bit RAM port between the instruction
// fetch unit and the load/store buffer, assembling and extending multi-byte accesses.
module mem_arbiter #(
   parameter int ADDR_WIDTH   = 32,
   parameter int LSB_ID_WIDTH = 3
) (
   input  logic                    clk,
   input  logic                    rst_in,
   input  logic                    rdy_in,
   input  logic                    clear,
   input  logic                    io_buffer_full,
   input  logic [7:0]              mem_din,
   output logic [7:0]              mem_dout,
   output logic [ADDR_WIDTH-1:0]   mem_aout,
   output logic                    mem_rw,
   input  logic                    if_req,
   input  logic [ADDR_WIDTH-1:0]   if_addr,
   output logic                    if_done,
   output logic [31:0]             if_inst,
   input  logic                    lsb_req,
   input  logic                    lsb_we,
   input  logic [ADDR_WIDTH-1:0]   lsb_addr,
   input  logic [31:0]             lsb_wdata,
   input  logic [2:0]              lsb_type,
   input  logic [LSB_ID_WIDTH-1:0] lsb_id,
   output logic                    lsb_done,
   output logic [31:0]             lsb_rdata,
   output logic [LSB_ID_WIDTH-1:0] lsb_id_out,
   output logic                    busy
);
   typedef enum logic [1:0] {IDLE, IFETCH, LOAD, STORE} state_t;

   state_t                  state, state_nx;
   logic [1:0]              cnt, cnt_nx;
   logic                    tail, tail_nx;
   logic                    last_lsb, last_lsb_nx;
   logic                    if_done_q, lsb_done_q, ld_done_q;
   logic                    if_done_nx, lsb_done_nx, ld_done_nx;
   logic                    cap_vld;
   logic [1:0]              cap_idx;
   logic [ADDR_WIDTH-1:0]   base;
   logic [31:0]             wdata, rbuf;
   logic [2:0]              ltype;
   logic [LSB_ID_WIDTH-1:0] id;
   logic                    grant, grant_lsb, active, stall, read_cyc;
   logic [1:0]              last_idx;

   function automatic logic [1:0] last_byte(input logic [1:0] t);
      case (t)
         2'b00:   return 2'd0;
         2'b01:   return 2'd1;
         default: return 2'd3;
      endcase
   endfunction

   function automatic logic [31:0] extend(input logic [2:0] t, input logic [31:0] d);
      case (t)
         3'b000:  return {{24{d[7]}}, d[7:0]};
         3'b001:  return {{16{d[15]}}, d[15:0]};
         3'b100:  return {24'h000000, d[7:0]};
         3'b101:  return {16'h0000, d[15:0]};
         default: return d;
      endcase
   endfunction

   // The tail cycle of a read carries no address; it only waits for the last byte.
   assign last_idx  = (state == IFETCH) ? 2'd3 : last_byte(ltype[1:0]);
   assign stall     = (state == STORE) && (base[17:16] == 2'b11) && io_buffer_full;
   assign active    = rdy_in && (state != IDLE) && !tail && !stall;
   assign read_cyc  = active && (state != STORE);
   assign grant     = rdy_in && (state == IDLE) && !clear && (lsb_req || if_req);
   assign grant_lsb = lsb_req && !(last_lsb && if_req);

   assign mem_aout   = active ? base + ADDR_WIDTH'(cnt) : '0;
   assign mem_rw     = active && (state == STORE);
   assign mem_dout   = mem_rw ? wdata[{cnt, 3'b000} +: 8] : 8'h00;
   assign busy       = (state != IDLE);
   assign if_done    = if_done_q;
   assign if_inst    = if_done_q ? rbuf : 32'h0;
   assign lsb_done   = lsb_done_q;
   assign lsb_rdata  = ld_done_q ? extend(ltype, rbuf) : 32'h0;
   assign lsb_id_out = ld_done_q ? id : '0;

   always_comb begin
      state_nx    = state;
      cnt_nx      = cnt;
      tail_nx     = tail;
      last_lsb_nx = last_lsb;
      if_done_nx  = 1'b0;
      lsb_done_nx = 1'b0;
      ld_done_nx  = 1'b0;
      case (state)
         IDLE: begin
            if (grant) begin
               state_nx    = grant_lsb ? (lsb_we ? STORE : LOAD) : IFETCH;
               last_lsb_nx = grant_lsb;
               cnt_nx      = 2'd0;
               tail_nx     = 1'b0;
            end
         end
         IFETCH, LOAD: begin
            if (clear) begin
               state_nx = IDLE;
               cnt_nx   = 2'd0;
               tail_nx  = 1'b0;
            end else if (tail) begin
               state_nx    = IDLE;
               cnt_nx      = 2'd0;
               tail_nx     = 1'b0;
               if_done_nx  = (state == IFETCH);
               lsb_done_nx = (state == LOAD);
               ld_done_nx  = (state == LOAD);
            end else if (cnt == last_idx) begin
               tail_nx = 1'b1;
            end else begin
               cnt_nx = cnt + 2'd1;
            end
         end
         STORE: begin
            if (!stall) begin
               if (cnt == last_idx) begin
                  state_nx    = IDLE;
                  cnt_nx      = 2'd0;
                  lsb_done_nx = 1'b1;
               end else begin
                  cnt_nx = cnt + 2'd1;
               end
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // A pending byte capture drains even while frozen so no RAM data is lost.
   always_ff @(posedge clk or posedge rst_in) begin
      if (rst_in) begin
         state      <= IDLE;
         cnt        <= 2'd0;
         tail       <= 1'b0;
         last_lsb   <= 1'b0;
         if_done_q  <= 1'b0;
         lsb_done_q <= 1'b0;
         ld_done_q  <= 1'b0;
         cap_vld    <= 1'b0;
         cap_idx    <= 2'd0;
      end else begin
         cap_vld <= read_cyc;
         cap_idx <= cnt;
         if (rdy_in) begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            tail       <= tail_nx;
            last_lsb   <= last_lsb_nx;
            if_done_q  <= if_done_nx;
            lsb_done_q <= lsb_done_nx;
            ld_done_q  <= ld_done_nx;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (cap_vld) rbuf[{cap_idx, 3'b000} +: 8] <= mem_din;
      if (grant) begin
         base <= grant_lsb ? lsb_addr : if_addr;
         if (grant_lsb) begin
            wdata <= lsb_wdata;
            ltype <= lsb_type;
            id    <= lsb_id;
         end
      end
   end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized bench for mem_arbiter with a byte RAM and a
// transaction-level reference model of loads, stores and fetches.
module tb_mem_arbiter;
   localparam int AW = 32;
   localparam int IW = 3;

   logic          clk = 1'b0;
   logic          rst_in = 1'b1;
   logic          rdy_in = 1'b0;
   logic          clear = 1'b0;
   logic          io_buffer_full = 1'b0;
   logic [7:0]    mem_din;
   logic [7:0]    mem_dout;
   logic [AW-1:0] mem_aout;
   logic          mem_rw;
   logic          if_req = 1'b0;
   logic [AW-1:0] if_addr = '0;
   logic          if_done;
   logic [31:0]   if_inst;
   logic          lsb_req = 1'b0;
   logic          lsb_we = 1'b0;
   logic [AW-1:0] lsb_addr = '0;
   logic [31:0]   lsb_wdata = '0;
   logic [2:0]    lsb_type = '0;
   logic [IW-1:0] lsb_id = '0;
   logic          lsb_done;
   logic [31:0]   lsb_rdata;
   logic [IW-1:0] lsb_id_out;
   logic          busy;

   mem_arbiter #(.ADDR_WIDTH(AW), .LSB_ID_WIDTH(IW)) dut (
      .clk(clk), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
      .io_buffer_full(io_buffer_full), .mem_din(mem_din), .mem_dout(mem_dout),
      .mem_aout(mem_aout), .mem_rw(mem_rw), .if_req(if_req), .if_addr(if_addr),
      .if_done(if_done), .if_inst(if_inst), .lsb_req(lsb_req), .lsb_we(lsb_we),
      .lsb_addr(lsb_addr), .lsb_wdata(lsb_wdata), .lsb_type(lsb_type), .lsb_id(lsb_id),
      .lsb_done(lsb_done), .lsb_rdata(lsb_rdata), .lsb_id_out(lsb_id_out), .busy(busy)
   );

   always #5 clk = ~clk;

   bit [7:0]    ram [0:262143];
   logic [31:0] wlog_a [0:255];
   logic [7:0]  wlog_d [0:255];
   int          wcnt = 0;
   int          cyc = 0;
   int          errors = 0;
   int          checks = 0;
   logic [2:0]  ltab [0:4];

   // Synchronous-read RAM; writes are only logged so the bench can replay them.
   always @(posedge clk) begin
      cyc     <= cyc + 1;
      mem_din <= ram[mem_aout[17:0]];
      if (mem_rw) begin
         wlog_a[wcnt[7:0]] <= mem_aout;
         wlog_d[wcnt[7:0]] <= mem_dout;
         wcnt              <= wcnt + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic poke(input int idx, input logic [7:0] b);
      ram[idx] = b;
   endtask

   function automatic int nbytes(input logic [2:0] t);
      if (t[1:0] == 2'b00) return 1;
      if (t[1:0] == 2'b01) return 2;
      return 4;
   endfunction

   function automatic logic [31:0] model_load(input logic [31:0] a, input logic [2:0] t);
      int     n;
      longint v;
      n = nbytes(t);
      v = 0;
      for (int k = 0; k < n; k++) v += longint'(ram[int'(a[17:0]) + k]) << (8 * k);
      if (!t[2] && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= (longint'(1) << (8 * n));
      return v[31:0];
   endfunction

   task automatic do_load(input string tag, input logic [31:0] a, input logic [2:0] t,
                          input logic [IW-1:0] id, input int clr_at);
      int g, rel, w0;
      bit seen;
      logic [31:0] exp;
      exp = model_load(a, t);
      w0 = wcnt;
      lsb_req = 1; lsb_we = 0; lsb_addr = a; lsb_type = t; lsb_id = id; lsb_wdata = $urandom;
      g = cyc;
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         tick;
         rel = cyc - g;
         if (lsb_done) begin seen = 1; break; end
         if (clr_at >= 0 && rel == clr_at + 1) chk({tag, "_idle_after_clear"}, 32'(busy), 32'd0);
         clear = (rel == clr_at);
         if (rel == clr_at) lsb_req = 0;
      end
      clear = 0;
      if (clr_at < 0) begin
         chk({tag, "_lat"}, 32'(cyc - g), 32'(nbytes(t) + 2));
         chk({tag, "_rdata"}, lsb_rdata, exp);
         chk({tag, "_id"}, 32'(lsb_id_out), 32'(id));
         lsb_req = 0;
         tick;
         chk({tag, "_done_low"}, 32'(lsb_done), 32'd0);
         chk({tag, "_rdata_zero"}, lsb_rdata, 32'd0);
      end else begin
         chk({tag, "_no_done"}, 32'(seen), 32'd0);
      end
      chk({tag, "_no_writes"}, 32'(wcnt - w0), 32'd0);
   endtask

   task automatic do_store(input string tag, input logic [31:0] a, input logic [31:0] d,
                           input logic [2:0] t, input int st_at, input int st_len, input int clr_at);
      int g, rel, w0, n, exp_lat;
      n = nbytes(t);
      exp_lat = n + 1;
      if (a[17:16] == 2'b11 && st_at >= 0 && st_at + 1 < n) exp_lat += st_len;
      w0 = wcnt;
      lsb_req = 1; lsb_we = 1; lsb_addr = a; lsb_type = t; lsb_wdata = d; lsb_id = IW'($urandom);
      g = cyc;
      for (int i = 0; i < 30; i++) begin
         tick;
         rel = cyc - g;
         if (lsb_done) break;
         io_buffer_full = (st_at >= 0) && (rel >= st_at + 2) && (rel < st_at + 2 + st_len);
         clear = (rel == clr_at);
      end
      chk({tag, "_lat"}, 32'(cyc - g), 32'(exp_lat));
      chk({tag, "_rdata_zero"}, lsb_rdata, 32'd0);
      chk({tag, "_id_zero"}, 32'(lsb_id_out), 32'd0);
      lsb_req = 0; io_buffer_full = 0; clear = 0; lsb_we = 0;
      chk({tag, "_nwrites"}, 32'(wcnt - w0), 32'(n));
      for (int k = 0; k < n; k++) begin
         chk({tag, "_waddr"}, wlog_a[8'(w0 + k)], a + 32'(k));
         chk({tag, "_wdata"}, 32'(wlog_d[8'(w0 + k)]), (d >> (8 * k)) & 32'hFF);
      end
   endtask

   task automatic do_fetch(input string tag, input logic [31:0] a, input int fz_at, input int fz_len);
      int g, rel;
      logic [31:0] exp;
      exp = model_load(a, 3'b010);
      if_req = 1; if_addr = a;
      g = cyc;
      for (int i = 0; i < 20; i++) begin
         tick;
         rel = cyc - g;
         if (if_done) break;
         if (fz_at < 0 && rel >= 1 && rel <= 4) chk({tag, "_addr"}, mem_aout, a + 32'(rel - 1));
         rdy_in = !(fz_at >= 0 && rel >= fz_at && rel < fz_at + fz_len);
      end
      rdy_in = 1;
      chk({tag, "_lat"}, 32'(cyc - g), 32'((fz_at >= 0) ? 6 + fz_len : 6));
      chk({tag, "_inst"}, if_inst, exp);
      if_req = 0;
      tick;
      chk({tag, "_done_low"}, 32'(if_done), 32'd0);
      chk({tag, "_inst_zero"}, if_inst, 32'd0);
   endtask

   initial begin
      int s, nd, lleft, ileft;
      int dcyc [0:3];
      bit dlsb [0:3];
      logic [31:0] a, d;
      ltab[0] = 3'b000; ltab[1] = 3'b001; ltab[2] = 3'b010; ltab[3] = 3'b100; ltab[4] = 3'b101;

      // reset with requests pending
      rdy_in = 1; lsb_req = 1; lsb_we = 1; if_req = 1;
      tick; tick;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_rw", 32'(mem_rw), 32'd0);
      chk("rst_aout", mem_aout, 32'd0);
      chk("rst_dout", 32'(mem_dout), 32'd0);
      chk("rst_if_done", 32'(if_done), 32'd0);
      chk("rst_if_inst", if_inst, 32'd0);
      chk("rst_lsb_done", 32'(lsb_done), 32'd0);
      chk("rst_lsb_rdata", lsb_rdata, 32'd0);
      chk("rst_id_out", 32'(lsb_id_out), 32'd0);
      lsb_req = 0; lsb_we = 0; if_req = 0; rst_in = 0;
      tick;

      poke('h100, 8'h13); poke('h101, 8'h00); poke('h102, 8'h00); poke('h103, 8'h00);
      do_fetch("ifetch_0x100", 32'h100, -1, 0);

      poke('h200, 8'h80); poke('h201, 8'hFF);
      do_load("lb", 32'h200, 3'b000, 3'd5, -1);
      chk("lb_value", model_load(32'h200, 3'b000), 32'hFFFFFF80);
      do_load("lbu", 32'h200, 3'b100, 3'd6, -1);
      do_load("lhu", 32'h200, 3'b101, 3'd1, -1);
      do_load("lh", 32'h200, 3'b001, 3'd2, -1);
      do_load("lw", 32'h200, 3'b010, 3'd3, -1);

      do_store("sw_io_stall", 32'h30000, 32'hAABBCCDD, 3'b010, 1, 3, -1);
      do_store("sw_nonio_full", 32'h1000, 32'h11223344, 3'b010, 0, 2, -1);
      do_store("sb", 32'h2001, 32'h000000A5, 3'b000, -1, 0, -1);
      do_store("sh_io", 32'h30010, 32'h0000BEEF, 3'b001, 0, 2, -1);

      do_load("load_clear", 32'h200, 3'b010, 3'd4, 2);
      do_store("store_clear", 32'h3000, 32'h01020304, 3'b010, -1, 0, 2);
      do_fetch("ifetch_freeze", 32'h100, 2, 2);

      // clear in IDLE suppresses the grant
      lsb_req = 1; lsb_we = 0; lsb_addr = 32'h200; lsb_type = 3'b010; clear = 1;
      tick;
      chk("idle_clear_no_grant", 32'(busy), 32'd0);
      clear = 0;
      do_load("after_idle_clear", 32'h200, 3'b010, 3'd7, -1);

      // arbitration with both requesters held, starting from reset
      rst_in = 1; tick; rst_in = 0;
      for (int k = 0; k < 4; k++) begin
         poke('h400 + k, 8'($urandom)); poke('h500 + k, 8'($urandom));
      end
      lsb_addr = 32'h400; lsb_type = 3'b010; lsb_we = 0; lsb_id = 3'd2; if_addr = 32'h500;
      lsb_req = 1; if_req = 1;
      s = cyc; nd = 0; lleft = 2; ileft = 2;
      for (int i = 0; i < 60 && nd < 4; i++) begin
         tick;
         if (lsb_done) begin
            chk("arb_lsb_rdata", lsb_rdata, model_load(32'h400, 3'b010));
            dcyc[nd] = cyc - s; dlsb[nd] = 1; nd++; lleft--; lsb_req = 0;
         end else if (!lsb_req && lleft > 0) lsb_req = 1;
         if (if_done) begin
            chk("arb_if_inst", if_inst, model_load(32'h500, 3'b010));
            dcyc[nd] = cyc - s; dlsb[nd] = 0; nd++; ileft--; if_req = 0;
         end else if (!if_req && ileft > 0) if_req = 1;
      end
      lsb_req = 0; if_req = 0;
      chk("arb_count", 32'(nd), 32'd4);
      for (int k = 0; k < nd; k++) begin
         chk("arb_order", 32'(dlsb[k]), 32'((k % 2) == 0));
         chk("arb_done_cycle", 32'(dcyc[k]), 32'(6 * (k + 1)));
      end
      tick;

      // asynchronous reset in the middle of a store
      lsb_req = 1; lsb_we = 1; lsb_addr = 32'h30000; lsb_type = 3'b010; lsb_wdata = 32'h55667788;
      tick; tick;
      chk("midrst_writing", 32'(mem_rw), 32'd1);
      #2 rst_in = 1;
      #1;
      chk("midrst_rw", 32'(mem_rw), 32'd0);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_aout", mem_aout, 32'd0);
      lsb_req = 0; lsb_we = 0;
      tick;
      rst_in = 0;
      tick;

      // randomized transactions
      for (int it = 0; it < 16; it++) begin
         case ($urandom_range(0, 2))
            0: begin
               a = 32'($urandom_range(0, 'h2FF00));
               for (int k = 0; k < 4; k++) poke(int'(a) + k, 8'($urandom));
               do_load("rnd_load", a, ltab[$urandom_range(0, 4)], IW'($urandom), -1);
            end
            1: begin
               a = ($urandom_range(0, 1) == 1) ? 32'h30000 + 32'($urandom_range(0, 255))
                                                : 32'($urandom_range(0, 'h2FF00));
               d = $urandom;
               do_store("rnd_store", a, d, ltab[$urandom_range(0, 2)],
                        $urandom_range(0, 2), $urandom_range(1, 3), -1);
            end
            default: begin
               a = 32'($urandom_range(0, 'h2FF00));
               for (int k = 0; k < 4; k++) poke(int'(a) + k, 8'($urandom));
               if ($urandom_range(0, 1) == 1)
                  do_fetch("rnd_fetch_frz", a, $urandom_range(1, 5), $urandom_range(1, 2));
               else
                  do_fetch("rnd_fetch", a, -1, 0);
            end
         endcase
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end
endmodule
